// File: rtl/spram_fifo_pkg.sv
// Shared definitions for the single-port-RAM streaming FIFO.
//   DEF_DATA_W / DEF_ADDR_W : default RAM aspect (spram512x40)
//   OUT_DEPTH               : entries in the prefetch output buffer
//   port_op_e               : what the single RAM port does this cycle
package spram_fifo_pkg;

  localparam int unsigned DEF_DATA_W = 40;
  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned OUT_DEPTH  = 2;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_WRITE,
    OP_READ
  } port_op_e;

endpackage

// File: rtl/spram_fifo_outbuf.sv
// Two-entry in-order prefetch buffer sitting behind the RAM read port.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : ram data lands this edge (push_data)
//   pop        : consumer takes the head this edge (ignored when empty)
//   occ        : entries held (0..OUT_DEPTH)
//   head       : oldest entry; stable until popped
module spram_fifo_outbuf
  import spram_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] e0;
  logic [DATA_W-1:0] e1;
  logic              do_pop;

  assign do_pop = pop && (occ != 2'd0);
  assign head   = e0;

  // The arbiter never issues a read that would land into a full buffer
  // without a simultaneous pop, so push-on-full is not handled here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      occ <= '0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (occ == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  logic unused_depth;
  assign unused_depth = (OUT_DEPTH == 0);

endmodule

// File: rtl/spram_stream_fifo.sv
// Deep streaming FIFO built on a single-port synchronous RAM macro.
// One RAM access per cycle is arbitrated between writes and prefetch
// reads; reads feed a 2-entry output buffer so the consumer can drain
// one word per cycle.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_data   : upstream push handshake
//   rd_valid/rd_ready/rd_data   : downstream pop handshake (head word)
//   count                       : words held (RAM + in flight + buffer)
//   ram_addr/ram_datain/ram_we  : macro port controls
//   ram_dataout                 : macro read data, one cycle after address
module spram_stream_fifo
  import spram_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W+1:0] count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_datain,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dataout
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   mem_cnt;
  logic              rd_inflight;
  logic [1:0]        out_occ;
  logic              mem_empty;
  logic              mem_full;
  logic              rd_urgent;
  logic              pop;
  logic [2:0]        out_load;
  port_op_e          op;

  assign mem_empty = (mem_cnt == '0);
  // DEPTH is 2**ADDR_W, so the top bit alone marks a full RAM
  assign mem_full  = mem_cnt[ADDR_W];
  assign rd_urgent = (out_occ == 2'd0) && !rd_inflight && !mem_empty;
  assign wr_ready  = rst_n && !mem_full && !rd_urgent;
  assign rd_valid  = (out_occ != 2'd0);
  assign pop       = rd_valid && rd_ready;
  // buffer entries that will be committed after this edge, not counting a new read
  assign out_load  = {1'b0, out_occ} + {2'b00, rd_inflight} - {2'b00, pop};

  always_comb begin
    op = OP_IDLE;
    if (wr_valid && wr_ready)
      op = OP_WRITE;
    else if (!mem_empty && (out_load < 3'(OUT_DEPTH)))
      op = OP_READ;
  end

  assign ram_we     = (op == OP_WRITE);
  assign ram_addr   = ram_we ? wr_ptr : rd_ptr;
  assign ram_datain = wr_data;
  assign count      = {1'b0, mem_cnt} + (ADDR_W+2)'(rd_inflight) + (ADDR_W+2)'(out_occ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= (op == OP_READ);
      case (op)
        OP_WRITE: begin
          wr_ptr  <= wr_ptr + ADDR_W'(1);
          mem_cnt <= mem_cnt + (ADDR_W+1)'(1);
        end
        OP_READ: begin
          rd_ptr  <= rd_ptr + ADDR_W'(1);
          mem_cnt <= mem_cnt - (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

  spram_fifo_outbuf #(
    .DATA_W(DATA_W)
  ) u_outbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_inflight),
    .push_data (ram_dataout),
    .pop       (pop),
    .occ       (out_occ),
    .head      (rd_data)
  );

endmodule

// File: doc/spram_stream_fifo.md
Name: spram_stream_fifo

Overview:
- Streaming FIFO controller that drives a single-port synchronous RAM macro (spram512x40 / spram1024x20 / spram2048x10 family) directly upstream of it.
- Arbitrates the one RAM port between writes and reads each cycle.
- Prefetches read data into a 2-entry output buffer, so that a downstream valid/ready consumer can stream one word per cycle.
- Used where the mapped BRAM must behave as a deep FIFO rather than an addressed memory.

Parameters:
- DATA_W, 40, RAM word width (40/20/10 for the three macro aspects).
- ADDR_W, 9, RAM address width (9/10/11). DEPTH = 2**ADDR_W; power of two by construction.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  upstream word present
- wr_ready  out  1  upstream word accepted when wr_valid && wr_ready
- wr_data  in  DATA_W  upstream word
- rd_valid  out  1  rd_data holds the oldest word
- rd_ready  in  1  consumer takes rd_data when rd_valid && rd_ready
- rd_data  out  DATA_W  head word
- count  out  ADDR_W+2  total words held (RAM + in-flight + output buffer), 0..DEPTH+2
- ram_addr  out  ADDR_W  to macro addr
- ram_datain  out  DATA_W  to macro datain; equals wr_data
- ram_we  out  1  to macro we
- ram_dataout  in  DATA_W  from macro dataout; valid the cycle after a read address is presented with we=0

Behaviour:
- State:
  - wr_ptr, rd_ptr (ADDR_W bits; wrap DEPTH-1 -> 0 naturally)
  - mem_cnt (0..DEPTH)
  - rd_inflight (1 bit)
  - out_occ (0..2)
- Per-cycle port op, one of OP_IDLE / OP_WRITE / OP_READ:
  - rd_urgent = out_occ==0 && !rd_inflight && mem_cnt>0
  - wr_ready = rst_n && mem_cnt<DEPTH && !rd_urgent
  - OP_WRITE when wr_valid && wr_ready: ram_we=1, ram_addr=wr_ptr; wr_ptr++ and mem_cnt++ at the edge.
  - OP_READ when there is no write && mem_cnt>0 && (out_occ + rd_inflight - pop) < 2, where pop = rd_valid && rd_ready. Then ram_we=0, ram_addr=rd_ptr; rd_ptr++, mem_cnt--, rd_inflight<=1.
  - OP_IDLE otherwise: ram_we=0, ram_addr=rd_ptr.
  - Read priority applies only when rd_urgent; otherwise write has priority.
- Read landing: rd_inflight=1 means ram_dataout is captured into the output buffer at the next edge, behind any entry still held.
- Output buffer: 2-entry in-order FIFO. rd_valid = out_occ>0; rd_data = head entry. Pop and land in the same cycle are legal.
- Output stability: while rd_valid && !rd_ready, rd_data holds stable.
- count = mem_cnt + rd_inflight + out_occ, registered-consistent with the above.
- Latency: a write handshake in cycle 0 on an empty FIFO gives a read issue in cycle 1, a RAM return in cycle 2, and rd_valid=1 in cycle 3.
- Throughput:
  - Sustained 1 word/cycle drain when no writes.
  - Mixed traffic shares the port; total of writes + reads is at most 1 per cycle.
- Full: mem_cnt==DEPTH gives wr_ready=0. Maximum count is DEPTH+2.
- Empty: count==0 gives rd_valid=0 and no read is issued. A write to an empty FIFO never bypasses the RAM.
- Reset:
  - rst_n low clears all state immediately, with no clock edge needed.
  - During reset: wr_ready=0, rd_valid=0, ram_we=0, ram_addr=0, count=0, rd_data=0.
  - Reset mid-stream discards all contents, including an in-flight read; RAM contents are not cleared.
- Simultaneous events:
  - Full + pop: wr_ready stays 0 that cycle, because mem_cnt, not count, gates writes.
  - Write and urgent read requested together: the read wins and the write retries.

Decomposition:
- Package spram_fifo_pkg:
  - Default DATA_W/ADDR_W
  - enum port_op_e {OP_IDLE, OP_WRITE, OP_READ}
  - Constant OUT_DEPTH=2
- Sub-module spram_fifo_outbuf: the 2-entry output buffer (push, push_data, pop, occ, head data). The arbiter and pointers stay in the top.

Test Plan:
- Reset release, single write 0x12_3456_789A in cycle 0 -> ram_we=1/ram_addr=0 in cycle 0; ram_we=0/ram_addr=0 in cycle 1; rd_valid=1 with rd_data=0x12_3456_789A in cycle 3; count=1 from cycle 1 until the pop.
- rd_ready=0, wr_valid=1 continuously with incrementing data -> exactly 514 words accepted (one cycle lost to each urgent read); then wr_ready=0 and count=514.
- After fill, rd_ready=1 and no writes -> 514 words in order at 1/cycle after the head; count reaches 0; rd_valid drops.
- Concurrent random wr_valid/rd_ready over 2000 words -> in-order data, no loss or duplication, wr_ptr/rd_ptr wrap past 511 -> 0 at least 3 times.
- rd_ready pattern 1,0,1,0 with a 10-word backlog -> rd_data stable on stalled cycles; exactly 10 pops in order.
- rst_n driven low asynchronously mid-stream (read in flight, count=7) -> wr_ready/rd_valid/ram_we/count become 0 before the next edge; after release, none of the old words appear and the first new write is read back first.
